// File: rtl/hrm_wait_pkg.sv
// -----------------------------------------------------------------------------
// hrm_wait_pkg
// Shared definitions for the wait_queue block and its FIFO.
//   - state_t     : controller state encoding
//   - DEF_WIDTH   : default delay-operand width
//   - DEF_DEPTH   : default FIFO depth (power of 2, 2..16)
//   - ARM_TIMEOUT : cycles of wait_busy=0 tolerated in ARM before retiring
// -----------------------------------------------------------------------------
package hrm_wait_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_DEPTH   = 4;
   localparam int ARM_TIMEOUT = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ARM,
      ST_RUN,
      ST_RETIRE
   } state_t;

endpackage

// File: rtl/wait_fifo.sv
// -----------------------------------------------------------------------------
// wait_fifo
// Synchronous FIFO holding delay operands for wait_queue.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : enqueue request and operand (dropped when full unless
//                     a pop happens in the same cycle)
//   pop             : dequeue request (ignored when empty)
//   head            : operand at the read pointer
//   full, empty     : occupancy flags
//   level           : current entry count (0..DEPTH)
// -----------------------------------------------------------------------------
module wait_fifo
   import hrm_wait_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign head  = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read after it
   // has been written, and leaving the array reset-free lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wait_queue.sv
// -----------------------------------------------------------------------------
// wait_queue
// Queues delay operands and feeds them one at a time to a downstream WAIT
// unit, retiring each entry once the WAIT unit has finished.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : enqueue an operand (dropped when full)
//   full, empty     : FIFO occupancy flags
//   level           : FIFO entry count
//   wait_din        : operand presented to WAIT, stable until the next pop
//   wait_start      : one-cycle start pulse to WAIT
//   wait_busy       : busy indication from WAIT
//   done            : one-cycle pulse per retired entry
//   idle            : controller in IDLE with an empty FIFO
//   retired_cnt     : saturating retired-entry count
// Build option: define WAIT_QUEUE_STATS_EN to enable retired_cnt; otherwise
// it is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module wait_queue
   import hrm_wait_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [WIDTH-1:0]         wait_din,
   output logic                     wait_start,
   input  logic                     wait_busy,
   output logic                     done,
   output logic                     idle,
   output logic [15:0]              retired_cnt
);

   state_t           state;
   logic [1:0]       arm_cnt;
   logic [WIDTH-1:0] head;
   logic             pop;

   // Only pop while WAIT is quiet, so a start can never overlap a busy unit.
   assign pop  = (state == ST_IDLE) && !empty && !wait_busy;
   assign idle = (state == ST_IDLE) && empty;

   wait_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         arm_cnt    <= '0;
         wait_din   <= '0;
         wait_start <= 1'b0;
         done       <= 1'b0;
      end else begin
         wait_start <= 1'b0;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  wait_din <= head;
                  // A zero delay needs no WAIT round trip; retire immediately.
                  if (head == '0) begin
                     state <= ST_RETIRE;
                     done  <= 1'b1;
                  end else begin
                     state      <= ST_ISSUE;
                     wait_start <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               state   <= ST_ARM;
               arm_cnt <= '0;
            end
            // WAIT may finish (or never go busy) before we see it; give up
            // after ARM_TIMEOUT quiet cycles.
            ST_ARM: begin
               if (wait_busy) begin
                  state <= ST_RUN;
               end else if (arm_cnt == 2'(ARM_TIMEOUT - 1)) begin
                  state <= ST_RETIRE;
                  done  <= 1'b1;
               end else begin
                  arm_cnt <= arm_cnt + 2'd1;
               end
            end
            ST_RUN: begin
               if (!wait_busy) begin
                  state <= ST_RETIRE;
                  done  <= 1'b1;
               end
            end
            ST_RETIRE: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

`ifdef WAIT_QUEUE_STATS_EN
   logic [15:0] stat_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_cnt <= '0;
      end else if (done && stat_cnt != 16'hFFFF) begin
         stat_cnt <= stat_cnt + 16'd1;
      end
   end

   assign retired_cnt = stat_cnt;
`else
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_wait_queue.sv
// -----------------------------------------------------------------------------
// tb_wait_queue
// Self-checking bench for wait_queue. A queue-based reference predicts each
// entry's start and done cycles from its pop cycle and the busy length the
// bench's WAIT model will apply; a negedge process compares every output
// every cycle. Directed scenarios pin the reference with literal latencies.
// -----------------------------------------------------------------------------
module tb_wait_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   typedef struct {
      int               cyc;
      logic [WIDTH-1:0] din;
   } ev_t;

   logic                   clk       = 1'b0;
   logic                   rst       = 1'b1;
   logic                   push      = 1'b0;
   logic [WIDTH-1:0]       push_data = '0;
   logic                   wait_busy = 1'b0;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] level;
   logic [WIDTH-1:0]       wait_din;
   logic                   wait_start;
   logic                   done;
   logic                   idle;
   logic [15:0]            retired_cnt;

   always #5 clk = ~clk;

   wait_queue #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_data   (push_data),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .wait_din    (wait_din),
      .wait_start  (wait_start),
      .wait_busy   (wait_busy),
      .done        (done),
      .idle        (idle),
      .retired_cnt (retired_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: cycle index, queued operands, and the timeline of the
   // entry currently being served.
   int               cyc      = 0;
   logic [WIDTH-1:0] q[$];
   int               free_at  = 0;
   int               start_at = -1;
   int               done_at  = -1;
   logic [WIDTH-1:0] exp_din  = '0;
   int               exp_rc   = 0;
   int               job_len  = 0;
   int               next_len = 0;

   // WAIT model: busy for job_len cycles after it sees wait_start.
   int   wcnt       = 0;
   logic start_seen = 1'b0;

   ev_t start_log[$];
   ev_t done_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("level",      32'(level),       32'(q.size()));
      check("full",       32'(full),        32'(q.size() == DEPTH));
      check("empty",      32'(empty),       32'(q.size() == 0));
      check("wait_din",   32'(wait_din),    32'(exp_din));
      check("wait_start", 32'(wait_start),  32'(cyc == start_at));
      check("done",       32'(done),        32'(cyc == done_at));
      check("idle",       32'(idle),        32'(cyc >= free_at && q.size() == 0));
`ifdef WAIT_QUEUE_STATS_EN
      check("retired_cnt", 32'(retired_cnt), 32'(exp_rc));
`else
      check("retired_cnt", 32'(retired_cnt), 32'd0);
`endif
      if (wait_start) start_log.push_back('{cyc, wait_din});
      if (done)       done_log.push_back('{cyc, wait_din});
      start_seen <= wait_start;
   end

   // Advance the reference across one rising edge using the inputs that were
   // applied during cycle 'cyc'.
   task automatic model_step();
      logic [WIDTH-1:0] v;
      if (rst) begin
         q.delete();
         free_at  = 0;
         start_at = -1;
         done_at  = -1;
         exp_din  = '0;
         exp_rc   = 0;
      end else begin
         if (cyc == done_at && exp_rc < 65535) exp_rc++;
         if (cyc >= free_at && q.size() > 0 && !wait_busy) begin
            v       = q.pop_front();
            exp_din = v;
            job_len = next_len;
            if (v == '0) begin
               start_at = -1;
               done_at  = cyc + 1;
            end else begin
               // start next cycle; busy covers the following job_len cycles;
               // with no busy the ARM timeout retires after two quiet cycles
               start_at = cyc + 1;
               done_at  = cyc + 3 + ((job_len == 0) ? 1 : job_len);
            end
            free_at = done_at + 1;
         end
         if (push && q.size() < DEPTH) q.push_back(push_data);
      end
      cyc++;
   endtask

   task automatic wait_step();
      if (rst)             wcnt = 0;
      else if (start_seen) wcnt = job_len;
      else if (wcnt > 0)   wcnt--;
   endtask

   // Called at negedge+1: drive one cycle of inputs, cross the rising edge,
   // and return at the next negedge+1.
   task automatic cycle(input logic p, input logic [WIDTH-1:0] d, input logic h);
      push      = p;
      push_data = d;
      wait_busy = h || (wcnt > 0);
      @(posedge clk);
      model_step();
      wait_step();
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle(1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      push      = 1'b0;
      wait_busy = 1'b0;
      wcnt      = 0;
      repeat (n) begin
         @(posedge clk);
         model_step();
         wait_step();
         @(negedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      start_log.delete();
      done_log.delete();
   endtask

   int               pc;
   logic [WIDTH-1:0] d;
   logic             h;

   initial begin
      do_reset(2);

      // Single nonzero operand, WAIT busy for 3 cycles.
      next_len = 3;
      clear_logs();
      pc = cyc;
      cycle(1'b1, 8'h03, 1'b0);
      run(10);
      check("a_start_count", 32'(start_log.size()), 32'd1);
      check("a_done_count",  32'(done_log.size()),  32'd1);
      if (start_log.size() > 0) begin
         check("a_start_latency", 32'(start_log[0].cyc - pc), 32'd2);
         check("a_start_din",     32'(start_log[0].din),      32'h03);
      end
      if (done_log.size() > 0) check("a_done_latency", 32'(done_log[0].cyc - pc), 32'd7);

      // Zero operand retires without issuing.
      clear_logs();
      pc = cyc;
      cycle(1'b1, 8'h00, 1'b0);
      run(6);
      check("b_start_count", 32'(start_log.size()), 32'd0);
      check("b_done_count",  32'(done_log.size()),  32'd1);
      if (done_log.size() > 0) check("b_done_latency", 32'(done_log[0].cyc - pc), 32'd2);
      check("b_level", 32'(level), 32'd0);

      // WAIT never goes busy: ARM timeout.
      next_len = 0;
      clear_logs();
      pc = cyc;
      cycle(1'b1, 8'h05, 1'b0);
      run(8);
      check("c_done_count", 32'(done_log.size()), 32'd1);
      if (done_log.size() > 0) check("c_done_latency", 32'(done_log[0].cyc - pc), 32'd5);

      // Fill to full while WAIT is held busy, drop a fifth push, then drain.
      do_reset(2);
      next_len = 1;
      clear_logs();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i + 1), 1'b1);
      check("d_full",  32'(full),  32'd1);
      check("d_level", 32'(level), 32'd4);
      cycle(1'b1, 8'h05, 1'b1);
      check("d_level_drop", 32'(level), 32'd4);
      run(40);
      check("d_done_count", 32'(done_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < done_log.size(); i++)
         check("d_done_order", 32'(done_log[i].din), 32'(i + 1));
`ifdef WAIT_QUEUE_STATS_EN
      check("d_retired_cnt", 32'(retired_cnt), 32'd4);
`else
      check("d_retired_cnt", 32'(retired_cnt), 32'd0);
`endif

      // Full FIFO with push and pop on the same edge.
      next_len = 2;
      clear_logs();
      cycle(1'b1, 8'h11, 1'b1);
      cycle(1'b1, 8'h22, 1'b1);
      cycle(1'b1, 8'h33, 1'b1);
      cycle(1'b1, 8'h44, 1'b1);
      cycle(1'b1, 8'h55, 1'b0);
      check("e_level_swap", 32'(level), 32'd4);
      run(50);
      check("e_done_count", 32'(done_log.size()), 32'd5);
      if (done_log.size() == 5) check("e_last_din", 32'(done_log[4].din), 32'h55);

      // Reset while an entry runs with two more queued.
      next_len = 6;
      cycle(1'b1, 8'h21, 1'b1);
      cycle(1'b1, 8'h22, 1'b1);
      cycle(1'b1, 8'h23, 1'b1);
      run(5);
      check("f_level_before", 32'(level), 32'd2);
      clear_logs();
      rst = 1'b1;
      #1;
      check("f_rst_level",      32'(level),      32'd0);
      check("f_rst_empty",      32'(empty),      32'd1);
      check("f_rst_full",       32'(full),       32'd0);
      check("f_rst_idle",       32'(idle),       32'd1);
      check("f_rst_wait_din",   32'(wait_din),   32'd0);
      check("f_rst_wait_start", 32'(wait_start), 32'd0);
      check("f_rst_done",       32'(done),       32'd0);
      check("f_rst_retired",    32'(retired_cnt), 32'd0);
      do_reset(2);
      run(10);
      check("f_no_done", 32'(done_log.size()), 32'd0);

      // Randomized traffic, busy lengths, stalls and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset(2);
         end else begin
            next_len = $urandom_range(0, 4);
            d        = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            h = (cyc >= free_at) && (wcnt == 0) && ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 99) < 45), d, h);
         end
      end
      run(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wait_queue.md
WAIT_QUEUE -- requirements
Module: wait_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, delay operand width (matches downstream WAIT din).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  enqueue request for push_data.
REQ-006 SHALL have port push_data  input  WIDTH  delay operand to enqueue.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-009 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-010 SHALL have port wait_din  output  WIDTH  operand to downstream WAIT din.
REQ-011 SHALL have port wait_start  output  1  one-cycle start pulse to WAIT.
REQ-012 SHALL have port wait_busy  input  1  busy from WAIT.
REQ-013 SHALL have port done  output  1  one-cycle pulse per retired entry.
REQ-014 SHALL have port idle  output  1  FSM in IDLE and FIFO empty.
REQ-015 SHALL have port retired_cnt  output  16  retired-entry count (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, ARM, RUN, RETIRE.
REQ-017 IDLE: when !empty, pop head into a wait_din register, go ISSUE; zero-valued operand goes directly to RETIRE without issuing.
REQ-018 ISSUE: assert wait_start for exactly one cycle, wait_din held stable, go ARM.
REQ-019 ARM: go RUN on wait_busy=1; if wait_busy stays 0 for 2 cycles go RETIRE (downstream finished or never busy).
REQ-020 RUN: stay while wait_busy=1; on wait_busy=0 go RETIRE.
REQ-021 RETIRE: pulse done one cycle, go IDLE; next entry pops earliest the following cycle.
REQ-022 wait_din SHALL remain stable from ISSUE until next pop.
REQ-023 push when full SHALL be dropped, level unchanged.
REQ-024 push and pop in same cycle SHALL leave level unchanged, both take effect, including when full.
REQ-025 read/write pointers SHALL wrap modulo DEPTH.
REQ-026 wait_start SHALL never assert while wait_busy=1 in IDLE/ISSUE entry.
REQ-027 Push-to-wait_start latency from empty/IDLE SHALL be 2 cycles.

Reset
REQ-028 On rst: FSM=IDLE, pointers=0, level=0, empty=1, full=0, wait_din=0, wait_start=0, done=0, idle=1, retired_cnt=0.
REQ-029 rst mid-operation SHALL discard all queued entries and in-flight operand; no done pulse.

Configuration
REQ-030 With WAIT_QUEUE_STATS_EN defined, retired_cnt SHALL increment on each done, saturating at 16'hFFFF.
REQ-031 Without WAIT_QUEUE_STATS_EN, retired_cnt SHALL be constant 0 and no counter logic generated.

Structure
REQ-032 Shared package hrm_wait_pkg SHALL hold FSM state enum, default WIDTH/DEPTH constants, ARM timeout constant (2).
REQ-033 FIFO SHALL be sub-module wait_fifo (push/pop/full/empty/level); FSM stays in wait_queue.

Verification
REQ-034 Reset 2 cycles, push 8'h03, WAIT model busy 3 cycles -> wait_start at cycle 2 after push, wait_din=03, done one cycle after busy falls.
REQ-035 Push 4 entries (01,02,03,04) back-to-back -> full=1 after 4th, fifth push dropped, done pulses in order, retired_cnt=4 with macro.
REQ-036 Push 8'h00 -> no wait_start, done after 2 cycles, level returns 0.
REQ-037 Full FIFO, push and pop same cycle -> level stays 4, new entry retires last.
REQ-038 Assert rst during RUN with 2 queued -> all outputs reset values, no done, idle=1.
REQ-039 Downstream never asserts busy -> done 2 cycles after ARM entry; without macro retired_cnt stays 0.
